event_encoder: RTL

- Sequential 16-to-4 encoder: the inverse of the select-to-one-hot decoder.
- Collects single-cycle one-hot or multi-hot event strobes into a sticky pending register.
- Emits one 4-bit index per accepted transfer on a valid/ready output, in round-robin order.
- Sits between event sources and any consumer that expects an encoded select value, e.g. one feeding a decoder downstream.

---
 rtl/event_encoder.sv | 88 ++++++++
 1 files changed

// File: rtl/event_encoder.sv
// ============================================================================
// Module  : event_encoder
// Purpose : Sticky event collector with round-robin 16-to-4 index encoder
//           feeding a valid/ready output register.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module event_encoder #(
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2**SEL_W-1:0]   in,
  output logic [SEL_W-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   pending,
  output logic                  overflow
);

  localparam int N = 2**SEL_W;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [N-1:0]     r_pending;
  logic [SEL_W-1:0] r_out;
  logic [SEL_W-1:0] r_ptr;
  logic             r_overflow;

  logic             w_found;
  logic [SEL_W-1:0] w_sel;
  logic [SEL_W-1:0] w_idx;
  logic             w_load;
  logic [N-1:0]     w_clear;
  logic [N-1:0]     w_pending_next;
  logic             w_drop;

  // Walk from ptr upward with wrap; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = r_ptr + SEL_W'(i);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_load         = ((r_state == S_EMPTY) || out_ready) && w_found;
  assign w_clear        = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign w_pending_next = (r_pending & ~w_clear) | in;
  // A bit being granted this edge is free to accept a fresh event.
  assign w_drop         = |(in & r_pending & ~w_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_pending  <= '0;
      r_out      <= '0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      r_overflow <= w_drop;
      if (w_load) begin
        r_out   <= w_sel;
        r_ptr   <= w_sel + SEL_W'(1);
        r_state <= S_FULL;
      end else if ((r_state == S_FULL) && out_ready) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = (r_state == S_FULL);
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire
